// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port arbiter between the painter and the overlay writer.
// Optional feature macro: FB_ARB_ROUND_ROBIN_EN (round-robin tie break in IDLE).
module fb_write_arbiter #(
   parameter int PIXEL_NUM       = 76800,
   parameter int PIXEL_NUM_WIDTH = $clog2(PIXEL_NUM),
   parameter int MAX_WAIT        = 4096,
   parameter int MAX_WAIT_WIDTH  = $clog2(MAX_WAIT + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       p_req,
   input  logic                       p_we,
   input  logic [PIXEL_NUM_WIDTH-1:0] p_addr,
   input  logic                       p_data,
   output logic                       p_gnt,
   input  logic                       o_req,
   input  logic                       o_we,
   input  logic [PIXEL_NUM_WIDTH-1:0] o_addr,
   input  logic                       o_data,
   output logic                       o_gnt,
   output logic [PIXEL_NUM_WIDTH-1:0] ram_write_addr,
   output logic                       ram_data,
   output logic                       ram_write_en,
   output logic                       starved_p,
   output logic                       starved_o,
   output logic                       drop_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_P = 2'd1,
      ST_OWN_O = 2'd2
   } state_t;

   localparam logic [MAX_WAIT_WIDTH-1:0] WAIT_SAT = MAX_WAIT_WIDTH'(MAX_WAIT);

   state_t                    state_q, state_d;
   logic [MAX_WAIT_WIDTH-1:0] wait_p_q, wait_p_d;
   logic [MAX_WAIT_WIDTH-1:0] wait_o_q, wait_o_d;
   logic                      starved_p_q, starved_p_d;
   logic                      starved_o_q, starved_o_d;
   logic                      drop_err_q, drop_err_d;
   logic                      tie_p_wins;

   // Waiting time is only meaningful while the requester is locked out.
   function automatic logic [MAX_WAIT_WIDTH-1:0] wait_next(
      input logic [MAX_WAIT_WIDTH-1:0] cnt,
      input logic                      req,
      input logic                      gnt
   );
      if (!req || gnt) begin
         return '0;
      end else if (cnt == WAIT_SAT) begin
         return cnt;
      end else begin
         return cnt + MAX_WAIT_WIDTH'(1);
      end
   endfunction

`ifdef FB_ARB_ROUND_ROBIN_EN
   logic last_o_q, last_o_d;

   // last_o_q=1 means the overlay was served last, so the painter wins the next tie.
   assign tie_p_wins = last_o_q;

   always_comb begin
      last_o_d = last_o_q;
      if (state_d == ST_OWN_P && state_q != ST_OWN_P) begin
         last_o_d = 1'b0;
      end else if (state_d == ST_OWN_O && state_q != ST_OWN_O) begin
         last_o_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_o_q <= 1'b1;
      end else begin
         last_o_q <= last_o_d;
      end
   end
`else
   assign tie_p_wins = 1'b1;
`endif

   assign p_gnt     = (state_q == ST_OWN_P);
   assign o_gnt     = (state_q == ST_OWN_O);
   assign starved_p = starved_p_q;
   assign starved_o = starved_o_q;
   assign drop_err  = drop_err_q;

   // Ownership is held until the owner drops req; handover skips IDLE.
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (p_req && o_req) begin
                  state_d = tie_p_wins ? ST_OWN_P : ST_OWN_O;
               end else if (p_req) begin
                  state_d = ST_OWN_P;
               end else if (o_req) begin
                  state_d = ST_OWN_O;
               end
            end
            ST_OWN_P: begin
               if (!p_req) begin
                  state_d = o_req ? ST_OWN_O : ST_IDLE;
               end
            end
            ST_OWN_O: begin
               if (!o_req) begin
                  state_d = p_req ? ST_OWN_P : ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wait_p_d = wait_p_q;
      wait_o_d = wait_o_q;
      if (en) begin
         wait_p_d = wait_next(wait_p_q, p_req, p_gnt);
         wait_o_d = wait_next(wait_o_q, o_req, o_gnt);
      end
      starved_p_d = starved_p_q | (wait_p_d == WAIT_SAT);
      starved_o_d = starved_o_q | (wait_o_d == WAIT_SAT);
      drop_err_d  = drop_err_q | (p_we & ~p_gnt) | (o_we & ~o_gnt);
   end

   // Zero-latency RAM mux; non-owner strobes never reach the RAM.
   always_comb begin
      ram_write_en   = 1'b0;
      ram_write_addr = '0;
      ram_data       = 1'b0;
      if (en) begin
         case (state_q)
            ST_OWN_P: begin
               ram_write_en   = p_we;
               ram_write_addr = p_addr;
               ram_data       = p_data;
            end
            ST_OWN_O: begin
               ram_write_en   = o_we;
               ram_write_addr = o_addr;
               ram_data       = o_data;
            end
            default: begin
               ram_write_en   = 1'b0;
               ram_write_addr = '0;
               ram_data       = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wait_p_q    <= '0;
         wait_o_q    <= '0;
         starved_p_q <= 1'b0;
         starved_o_q <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_p_q    <= wait_p_d;
         wait_o_q    <= wait_o_d;
         starved_p_q <= starved_p_d;
         starved_o_q <= starved_o_d;
         drop_err_q  <= drop_err_d;
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_fb_write_arbiter;

   localparam int PIXEL_NUM = 76800;
   localparam int AW        = $clog2(PIXEL_NUM);
   localparam int MAX_WAIT  = 4096;

   logic          clk = 1'b0;
   logic          reset, en;
   logic          p_req, p_we, p_data, p_gnt;
   logic          o_req, o_we, o_data, o_gnt;
   logic [AW-1:0] p_addr, o_addr, ram_write_addr;
   logic          ram_data, ram_write_en, starved_p, starved_o, drop_err;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: owner 0=none, 1=painter, 2=overlay.
   int m_owner;
   bit m_last_o;
   int m_wp, m_wo;
   bit m_sp, m_so, m_drop;

   fb_write_arbiter dut (
      .clk(clk), .reset(reset), .en(en),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_gnt(p_gnt),
      .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .o_gnt(o_gnt),
      .ram_write_addr(ram_write_addr), .ram_data(ram_data), .ram_write_en(ram_write_en),
      .starved_p(starved_p), .starved_o(starved_o), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench timed out");
   end

   task automatic model_step();
      int nxt;
      if (reset) begin
         m_owner = 0; m_last_o = 1; m_wp = 0; m_wo = 0;
         m_sp = 0; m_so = 0; m_drop = 0;
      end else begin
         if ((p_we && m_owner != 1) || (o_we && m_owner != 2)) m_drop = 1;
         if (en) begin
            m_wp = (p_req && m_owner != 1) ? ((m_wp < MAX_WAIT) ? m_wp + 1 : m_wp) : 0;
            m_wo = (o_req && m_owner != 2) ? ((m_wo < MAX_WAIT) ? m_wo + 1 : m_wo) : 0;
            if (m_wp >= MAX_WAIT) m_sp = 1;
            if (m_wo >= MAX_WAIT) m_so = 1;
            nxt = m_owner;
            if (m_owner == 0) begin
               if (p_req && o_req) begin
`ifdef FB_ARB_ROUND_ROBIN_EN
                  nxt = m_last_o ? 1 : 2;
`else
                  nxt = 1;
`endif
               end else if (p_req) nxt = 1;
               else if (o_req) nxt = 2;
            end else if (m_owner == 1 && !p_req) begin
               nxt = o_req ? 2 : 0;
            end else if (m_owner == 2 && !o_req) begin
               nxt = p_req ? 1 : 0;
            end
            if (nxt != m_owner && nxt != 0) m_last_o = (nxt == 2);
            m_owner = nxt;
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      en = 1; p_req = 0; p_we = 0; p_addr = '0; p_data = 0;
      o_req = 0; o_we = 0; o_addr = '0; o_data = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      adv();
      adv();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++; if (p_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_p_gnt: got %b want 0", p_gnt); end
      vectors++; if (o_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_o_gnt: got %b want 0", o_gnt); end
      vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", ram_write_en); end
      vectors++; if (ram_write_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", ram_write_addr); end
      vectors++; if ({starved_p, starved_o, drop_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {starved_p, starved_o, drop_err}); end
   endtask

   task automatic test_basic();
      do_reset();
      p_req = 1;
      #1;
      vectors++; if (p_gnt !== 1'b0) begin miscompares++; $display("FAIL basic_early_gnt: got %b want 0", p_gnt); end
      adv();
      p_we = 1; p_addr = AW'(1000); p_data = 1;
      #1;
      vectors++; if (p_gnt !== 1'b1) begin miscompares++; $display("FAIL basic_p_gnt: got %b want 1", p_gnt); end
      vectors++; if (o_gnt !== 1'b0) begin miscompares++; $display("FAIL basic_o_gnt: got %b want 0", o_gnt); end
      vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("FAIL basic_we: got %b want 1", ram_write_en); end
      vectors++; if (ram_write_addr !== AW'(1000)) begin miscompares++; $display("FAIL basic_addr: got %0d want 1000", ram_write_addr); end
      vectors++; if (ram_data !== 1'b1) begin miscompares++; $display("FAIL basic_data: got %b want 1", ram_data); end
      adv();
      p_we = 0;
      adv();
      p_req = 0;
      adv();
      #1;
      vectors++; if (p_gnt !== 1'b0 || ram_write_en !== 1'b0) begin miscompares++; $display("FAIL basic_release: got gnt=%b we=%b want 0 0", p_gnt, ram_write_en); end
   endtask

   task automatic test_burst();
      do_reset();
      p_req = 1;
      adv();
      for (int i = 0; i < 6000; i++) begin
         p_we = 1; p_addr = AW'(i); p_data = i[0];
         if (i == 500) o_req = 1;
         #1;
         vectors++; if (o_gnt !== 1'b0) begin miscompares++; $display("FAIL burst_o_gnt @%0d: got %b want 0", i, o_gnt); end
         vectors++; if (ram_write_en !== 1'b1 || ram_write_addr !== AW'(i)) begin miscompares++; $display("FAIL burst_write @%0d: got we=%b addr=%0d want 1 %0d", i, ram_write_en, ram_write_addr, i); end
         adv();
      end
      p_we = 0; p_req = 0;
      #1;
      vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL burst_release_we: got %b want 0", ram_write_en); end
      adv();
      #1;
      vectors++; if (o_gnt !== 1'b1 || p_gnt !== 1'b0) begin miscompares++; $display("FAIL burst_handover: got p=%b o=%b want 0 1", p_gnt, o_gnt); end
      vectors++; if (starved_o !== 1'b1) begin miscompares++; $display("FAIL burst_starved_o: got %b want 1", starved_o); end
      vectors++; if (starved_p !== 1'b0 || drop_err !== 1'b0) begin miscompares++; $display("FAIL burst_flags: got sp=%b de=%b want 0 0", starved_p, drop_err); end
      o_req = 0;
      adv();
   endtask

   task automatic test_starve_boundary();
      do_reset();
      p_req = 1;
      adv();
      o_req = 1;
      repeat (MAX_WAIT - 1) adv();
      #1;
      vectors++; if (starved_o !== 1'b0) begin miscompares++; $display("FAIL starve_4095: got %b want 0", starved_o); end
      adv();
      #1;
      vectors++; if (starved_o !== 1'b1) begin miscompares++; $display("FAIL starve_4096: got %b want 1", starved_o); end
      p_req = 0; o_req = 0;
      adv();
      adv();
      #1;
      vectors++; if (starved_o !== 1'b1) begin miscompares++; $display("FAIL starve_sticky: got %b want 1", starved_o); end
   endtask

   task automatic test_tie();
      bit exp_p [3];
`ifdef FB_ARB_ROUND_ROBIN_EN
      exp_p = '{1'b1, 1'b0, 1'b1};
`else
      exp_p = '{1'b1, 1'b1, 1'b1};
`endif
      do_reset();
      for (int k = 0; k < 3; k++) begin
         p_req = 1; o_req = 1;
         adv();
         #1;
         vectors++; if (p_gnt !== exp_p[k] || o_gnt !== !exp_p[k]) begin miscompares++; $display("FAIL tie_%0d: got p=%b o=%b want %b %b", k, p_gnt, o_gnt, exp_p[k], !exp_p[k]); end
         p_req = 0; o_req = 0;
         adv();
         #1;
         vectors++; if (p_gnt !== 1'b0 || o_gnt !== 1'b0) begin miscompares++; $display("FAIL tie_idle_%0d: got p=%b o=%b want 0 0", k, p_gnt, o_gnt); end
      end
   endtask

   task automatic test_drop();
      do_reset();
      p_req = 1;
      adv();
      p_we = 1; p_addr = AW'(5); p_data = 1;
      o_we = 1; o_addr = AW'(9); o_data = 0;
      #1;
      vectors++; if (ram_write_en !== 1'b1 || ram_write_addr !== AW'(5) || ram_data !== 1'b1) begin miscompares++; $display("FAIL drop_mux: got we=%b addr=%0d d=%b want 1 5 1", ram_write_en, ram_write_addr, ram_data); end
      adv();
      #1;
      vectors++; if (drop_err !== 1'b1) begin miscompares++; $display("FAIL drop_set: got %b want 1", drop_err); end
      p_we = 0;
      #1;
      vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL drop_o_only: got %b want 0", ram_write_en); end
      o_we = 0;
      repeat (3) adv();
      p_req = 0;
      adv();
      adv();
      #1;
      vectors++; if (drop_err !== 1'b1) begin miscompares++; $display("FAIL drop_sticky: got %b want 1", drop_err); end
   endtask

   task automatic test_enable();
      do_reset();
      p_req = 1;
      adv();
      o_req = 1;
      repeat (MAX_WAIT - 1) adv();
      en = 0; p_req = 0; p_we = 1; p_addr = AW'(123); p_data = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         vectors++; if (p_gnt !== 1'b1 || o_gnt !== 1'b0) begin miscompares++; $display("FAIL en_frozen_gnt @%0d: got p=%b o=%b want 1 0", i, p_gnt, o_gnt); end
         vectors++; if (ram_write_en !== 1'b0 || ram_write_addr !== '0) begin miscompares++; $display("FAIL en_frozen_ram @%0d: got we=%b addr=%0d want 0 0", i, ram_write_en, ram_write_addr); end
         vectors++; if (starved_o !== 1'b0) begin miscompares++; $display("FAIL en_frozen_cnt @%0d: got %b want 0", i, starved_o); end
         adv();
      end
      en = 1; p_req = 1; p_we = 0;
      adv();
      #1;
      vectors++; if (p_gnt !== 1'b1) begin miscompares++; $display("FAIL en_resume_gnt: got %b want 1", p_gnt); end
      vectors++; if (starved_o !== 1'b1) begin miscompares++; $display("FAIL en_resume_cnt: got %b want 1", starved_o); end
      vectors++; if (drop_err !== 1'b0) begin miscompares++; $display("FAIL en_drop: got %b want 0", drop_err); end
      p_req = 0; o_req = 0;
      adv();
   endtask

   task automatic test_reset_mid();
      do_reset();
      o_req = 1;
      adv();
      o_we = 1; o_addr = AW'(77); o_data = 1;
      #1;
      vectors++; if (o_gnt !== 1'b1 || ram_write_en !== 1'b1 || ram_write_addr !== AW'(77)) begin miscompares++; $display("FAIL rmid_write: got g=%b we=%b addr=%0d want 1 1 77", o_gnt, ram_write_en, ram_write_addr); end
      p_we = 1;
      adv();
      p_we = 0;
      #1;
      vectors++; if (drop_err !== 1'b1) begin miscompares++; $display("FAIL rmid_drop: got %b want 1", drop_err); end
      reset = 1;
      adv();
      #1;
      vectors++; if (o_gnt !== 1'b0 || p_gnt !== 1'b0) begin miscompares++; $display("FAIL rmid_gnt: got p=%b o=%b want 0 0", p_gnt, o_gnt); end
      vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL rmid_we: got %b want 0", ram_write_en); end
      vectors++; if ({starved_p, starved_o, drop_err} !== 3'b000) begin miscompares++; $display("FAIL rmid_flags: got %b want 000", {starved_p, starved_o, drop_err}); end
      reset = 0;
      clear_inputs();
      adv();
   endtask

   task automatic test_random();
      logic          e_we, e_data;
      logic [AW-1:0] e_addr;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) p_req = ~p_req;
         if ($urandom_range(0, 7) == 0) o_req = ~o_req;
         en     = ($urandom_range(0, 15) != 0);
         p_we   = 1'($urandom_range(0, 1));
         o_we   = 1'($urandom_range(0, 1));
         p_data = 1'($urandom_range(0, 1));
         o_data = 1'($urandom_range(0, 1));
         p_addr = AW'($urandom_range(0, PIXEL_NUM - 1));
         o_addr = AW'($urandom_range(0, PIXEL_NUM - 1));
         #1;
         e_we = 0; e_addr = '0; e_data = 0;
         if (en && m_owner == 1) begin e_we = p_we; e_addr = p_addr; e_data = p_data; end
         if (en && m_owner == 2) begin e_we = o_we; e_addr = o_addr; e_data = o_data; end
         vectors++; if (p_gnt !== (m_owner == 1) || o_gnt !== (m_owner == 2)) begin miscompares++; $display("FAIL rand_gnt @%0d: got p=%b o=%b want owner %0d", c, p_gnt, o_gnt, m_owner); end
         vectors++; if (ram_write_en !== e_we) begin miscompares++; $display("FAIL rand_we @%0d: got %b want %b", c, ram_write_en, e_we); end
         vectors++; if (ram_write_addr !== e_addr || ram_data !== e_data) begin miscompares++; $display("FAIL rand_addr_data @%0d: got %0d/%b want %0d/%b", c, ram_write_addr, ram_data, e_addr, e_data); end
         vectors++; if (drop_err !== m_drop) begin miscompares++; $display("FAIL rand_drop @%0d: got %b want %b", c, drop_err, m_drop); end
         vectors++; if (starved_p !== m_sp || starved_o !== m_so) begin miscompares++; $display("FAIL rand_starved @%0d: got %b%b want %b%b", c, starved_p, starved_o, m_sp, m_so); end
         adv();
      end
      reset = 0;
      clear_inputs();
      adv();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_basic();
      test_burst();
      test_starve_boundary();
      test_tie();
      test_drop();
      test_enable();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
